// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op codes follow the RV32M funct3 encoding.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_mulh(op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_a_signed(op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and the muldiv unit (slave).
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/muldiv_addsub.sv
// Carry-lookahead adder/subtractor: sum = a + (sub ? ~b : b) + sub.
// 4-bit lookahead groups with group generate/propagate chained between groups.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = (W + 3) / 4;
  localparam int WP = NG * 4;

  logic [W-1:0]  b_eff;
  logic [WP-1:0] a_pad, b_pad, g, p;
  logic [WP:0]   c;
  logic [NG-1:0] grp_g, grp_p;
  logic          unused_carry;

  assign b_eff = sub ? ~b : b;
  assign a_pad = {{(WP-W){1'b0}}, a};
  assign b_pad = {{(WP-W){1'b0}}, b_eff};
  assign g     = a_pad & b_pad;
  assign p     = a_pad ^ b_pad;
  assign c[0]  = sub;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign c[B+1] = g[B] | (p[B] & c[B]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[B]);
      assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi] = &p[B+3:B];
      assign c[B+4]    = grp_g[gi] | (grp_p[gi] & c[B]);
    end
  endgenerate

  assign sum  = p[W-1:0] ^ c[W-1:0];
  assign cout = c[W];
  // Padding bits above W only exist to keep the groups uniform.
  assign unused_carry = ^c[WP:W+1];
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one 33-bit add/sub per cycle over 32 iterations, then a sign-fix cycle.
// Optional abort input enabled with MULDIV_KILL_EN.
module muldiv_seq #(
  parameter int XLEN  = muldiv_pkg::XLEN,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     rst,
`ifdef MULDIV_KILL_EN
  input  logic     kill,
`endif
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITER);

  state_e           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  op_e              op_reg, op_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic [TAG_W-1:0] out_tag_reg, out_tag_next;
  logic             neg_reg, neg_next;
  logic [XLEN-1:0]  hi_reg, hi_next;
  logic [XLEN-1:0]  lo_reg, lo_next;
  logic [XLEN-1:0]  b_reg, b_next;
  logic [XLEN-1:0]  result_reg, result_next;
  logic             out_valid_reg, out_valid_next;

  logic [XLEN:0]    add_a, add_b, add_sum;
  logic             add_sub, add_cout;

  op_e              in_op_e;
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  abs_a, abs_b, special_res, fix_sel;

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand conditioning at accept: magnitudes go into the datapath, signs into neg.
  assign in_op_e  = op_e'(bus.in_op);
  assign a_neg    = op_a_signed(in_op_e) & bus.in_a[XLEN-1];
  assign b_neg    = op_b_signed(in_op_e) & bus.in_b[XLEN-1];
  assign abs_a    = a_neg ? -bus.in_a : bus.in_a;
  assign abs_b    = b_neg ? -bus.in_b : bus.in_b;
  assign div_zero = op_is_div(in_op_e) && (bus.in_b == '0);
  assign div_ovf  = (in_op_e == OP_DIV || in_op_e == OP_REM)
                 && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_b == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_is_rem(in_op_e) ? bus.in_a : '1;
    else if (div_ovf)
      special_res = op_is_rem(in_op_e) ? '0 : bus.in_a;
  end

  // hi holds the product high half / remainder, lo the product low half / quotient.
  assign fix_sel = (op_is_mulh(op_reg) || op_is_rem(op_reg)) ? hi_reg : lo_reg;

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    op_next        = op_reg;
    tag_next       = tag_reg;
    out_tag_next   = out_tag_reg;
    neg_next       = neg_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    b_next         = b_reg;
    result_next    = result_reg;
    out_valid_next = out_valid_reg;
    add_a          = '0;
    add_b          = '0;
    add_sub        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_next    = in_op_e;
          tag_next   = bus.in_tag;
          neg_next   = op_is_rem(in_op_e) ? a_neg : (a_neg ^ b_neg);
          count_next = '0;
          hi_next    = '0;
          lo_next    = abs_a;
          b_next     = abs_b;
          if (div_zero || div_ovf) begin
            result_next    = special_res;
            out_tag_next   = bus.in_tag;
            out_valid_next = 1'b1;
            state_next     = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (op_is_div(op_reg)) begin
          // Restoring step: shift next dividend bit in, keep trial only if no borrow.
          add_a   = {hi_reg, lo_reg[XLEN-1]};
          add_b   = {1'b0, b_reg};
          add_sub = 1'b1;
          hi_next = add_cout ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
          lo_next = {lo_reg[XLEN-2:0], add_cout};
        end else begin
          add_a   = {1'b0, hi_reg};
          add_b   = lo_reg[0] ? {1'b0, b_reg} : '0;
          hi_next = add_sum[XLEN:1];
          lo_next = {add_sum[0], lo_reg[XLEN-1:1]};
        end
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(ITER - 1))
          state_next = ST_FIX;
      end

      ST_FIX: begin
        result_next = fix_sel;
        if (neg_reg) begin
          // High half of -{hi,lo} is ~hi, plus one only when lo is zero.
          if (op_is_mulh(op_reg) && (lo_reg != '0)) begin
            add_a = {1'b0, ~hi_reg};
          end else begin
            add_b   = {1'b0, fix_sel};
            add_sub = 1'b1;
          end
          result_next = add_sum[XLEN-1:0];
        end
        out_tag_next   = tag_reg;
        out_valid_next = 1'b1;
        state_next     = ST_DONE;
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

`ifdef MULDIV_KILL_EN
    if (kill) begin
      state_next     = ST_IDLE;
      out_valid_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      op_reg        <= OP_MUL;
      tag_reg       <= '0;
      out_tag_reg   <= '0;
      neg_reg       <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      op_reg        <= op_next;
      tag_reg       <= tag_next;
      out_tag_reg   <= out_tag_next;
      neg_reg       <= neg_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      b_reg         <= b_next;
      result_reg    <= result_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready   = (state_reg == ST_IDLE);
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = result_reg;
  assign bus.out_tag    = out_tag_reg;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, special cases, hold/abort, then random ops vs a model.
// Build with MULDIV_KILL_EN defined to also exercise the kill input.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MULDIV_KILL_EN
  logic kill = 1'b0;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef MULDIV_KILL_EN
    .kill (kill),
`endif
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, su;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    su = longint'(ub);
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * su; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready_pre"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_tag   = 5'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, 64'(bus.out_result), 64'(exp));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_result"}, 64'(bus.out_result), 64'(exp));
      chk({name, "_hold_tag"}, 64'(bus.out_tag), 64'(tag));
      chk({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({name, "_hold_busy"}, 64'(bus.busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({name, "_post_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // Starts a MUL and returns at the cycle where the unit is in CALC with count=12.
  task automatic start_and_reach_count12();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.in_a     = 32'h1234;
    bus.in_b     = 32'h5678;
    bus.in_tag   = 5'h0A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic watch_no_output(input string name);
    int seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk({name, "_no_output"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    int          sel;

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_result", 64'(bus.out_result), 64'd0);
    chk("reset_out_tag", 64'(bus.out_tag), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    run_op("mul_7xm3",      3'd0, 32'd7,        32'hFFFFFFFD, 5'h01, 32'hFFFFFFEB, 34, 0);
    run_op("mulhu_max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 34, 0);
    run_op("mulh_min",      3'd1, 32'h80000000, 32'h80000000, 5'h03, 32'h40000000, 34, 0);
    run_op("mulhsu_m1",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 34, 0);
    run_op("div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        5'h05, 32'hFFFFFFFD, 34, 0);
    run_op("rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        5'h06, 32'hFFFFFFFF, 34, 0);
    run_op("divu_100_7",    3'd5, 32'd100,      32'd7,        5'h07, 32'd14,       34, 0);
    run_op("remu_100_7",    3'd7, 32'd100,      32'd7,        5'h08, 32'd2,        34, 0);
    run_op("divu_by0",      3'd5, 32'd5,        32'd0,        5'h09, 32'hFFFFFFFF, 1,  0);
    run_op("remu_by0",      3'd7, 32'd5,        32'd0,        5'h0A, 32'd5,        1,  0);
    run_op("div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'h80000000, 1,  0);
    run_op("rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'd0,        1,  0);
    run_op("hold_divu",     3'd5, 32'd100,      32'd7,        5'h15, 32'd14,       34, 10);

    start_and_reach_count12();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_abort_busy", 64'(bus.busy), 64'd0);
    chk("rst_abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_abort_out_result", 64'(bus.out_result), 64'd0);
    watch_no_output("rst_abort");
    run_op("after_rst_mul", 3'd0, 32'd3, 32'd4, 5'h1F, 32'd12, 34, 0);

`ifdef MULDIV_KILL_EN
    start_and_reach_count12();
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_abort_busy", 64'(bus.busy), 64'd0);
    chk("kill_abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("kill_abort_in_ready", 64'(bus.in_ready), 64'd1);
    watch_no_output("kill_abort");
    run_op("after_kill_mul", 3'd0, 32'd3, 32'd4, 5'h1E, 32'd12, 34, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end else if (sel == 2) begin
        b = $urandom_range(1, 20);
      end else begin
        b = $urandom;
      end
      tag = 5'($urandom);
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, tag, ref_result(op, a, b),
             ref_latency(op, a, b), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
